// File: rtl/memacc_lsu_if.sv
// Execute-to-LSU request bus and LSU-to-writeback result bus for memacc_lsu.
// Execute drives the request (master) and holds it while stall is high.
interface memacc_lsu_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              valid_in;
  logic [XLEN-1:0]   exec_data_in;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [2:0]        mem_funct3;
  logic [XLEN-1:0]   mem_write_data;
  logic [XLEN-1:0]   next_pc_in;
  logic              rd_write_enable_in;
  logic [REG_AW-1:0] rd_write_addr_in;
  logic              res_src_in;

  logic              stall;
  logic              valid_out;
  logic [XLEN-1:0]   exec_data_out;
  logic [XLEN-1:0]   mem_data_out;
  logic [XLEN-1:0]   next_pc_out;
  logic              rd_write_enable_out;
  logic [REG_AW-1:0] rd_write_addr_out;
  logic              res_src_out;
  logic              misaligned_out;

  modport master (
    output flush, valid_in, exec_data_in, mem_read_enable, mem_write_enable,
           mem_funct3, mem_write_data, next_pc_in, rd_write_enable_in,
           rd_write_addr_in, res_src_in,
    input  stall, valid_out, exec_data_out, mem_data_out, next_pc_out,
           rd_write_enable_out, rd_write_addr_out, res_src_out, misaligned_out
  );

  modport slave (
    input  flush, valid_in, exec_data_in, mem_read_enable, mem_write_enable,
           mem_funct3, mem_write_data, next_pc_in, rd_write_enable_in,
           rd_write_addr_in, res_src_in,
    output stall, valid_out, exec_data_out, mem_data_out, next_pc_out,
           rd_write_enable_out, rd_write_addr_out, res_src_out, misaligned_out
  );
endinterface

// File: rtl/memacc_lsu.sv
// RV32 load/store stage: B/H/W loads with extension, byte-lane stores, fault detect.
// Latency MEM_LATENCY cycles for memory ops, 1 otherwise; stall holds execute until completion.
module memacc_lsu #(
  parameter int XLEN        = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 1,
  parameter int REG_AW      = 5
) (
  input logic         clk,
  input logic         rst_n,
  memacc_lsu_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              mem_op, fault, complete, stall_raw;
  logic [XLEN-1:0]   addr;
  logic [AW-1:0]     idx;
  logic [31:0]       mem [MEM_DEPTH];
  logic [31:0]       rd_word, wr_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        lane_en;
  logic [XLEN-1:0]   load_ext;

  logic              valid_q, rd_we_q, res_src_q, mis_q;
  logic [XLEN-1:0]   exec_q, mdat_q, pc_q;
  logic [REG_AW-1:0] rd_addr_q;

  assign addr   = bus.exec_data_in;
  assign idx    = addr[AW+1:2];
  assign mem_op = bus.mem_read_enable | bus.mem_write_enable;

  // Illegal sizes (011, 11x) and unaligned H/W accesses are all reported as one fault.
  assign fault = mem_op &&
                 ((bus.mem_funct3[1:0] == 2'b11) ||
                  (bus.mem_funct3[2] && bus.mem_funct3[1]) ||
                  (bus.mem_funct3[1:0] == 2'b01 && addr[0]) ||
                  (bus.mem_funct3[1:0] == 2'b10 && addr[1:0] != 2'b00));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.valid_in && mem_op && !SINGLE_CYCLE) state_nxt = WAIT;
      WAIT: if (wait_cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // FSM outputs
  always_comb begin
    stall_raw = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = bus.valid_in && mem_op && !SINGLE_CYCLE;
        complete  = bus.valid_in && (!mem_op || SINGLE_CYCLE);
      end
      WAIT: begin
        stall_raw = (wait_cnt != 4'd1);
        complete  = (wait_cnt == 4'd1);
      end
      default: ;
    endcase
    if (bus.flush) complete = 1'b0;
  end

  // Execute may still be holding a memory op while reset is applied.
  assign bus.stall = stall_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= 4'd0;
    else if (bus.flush)              wait_cnt <= 4'd0;
    else if (state == IDLE && state_nxt == WAIT)
                                     wait_cnt <= 4'(MEM_LATENCY - 1);
    else if (state == WAIT)          wait_cnt <= wait_cnt - 4'd1;
  end

  always_comb begin
    lane_en = 4'b0000;
    wr_word = bus.mem_write_data[31:0];
    case (bus.mem_funct3[1:0])
      2'b00: begin
        lane_en = 4'b0001 << addr[1:0];
        wr_word = {4{bus.mem_write_data[7:0]}};
      end
      2'b01: begin
        lane_en = addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{bus.mem_write_data[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (complete && bus.mem_write_enable && !fault) begin
      for (int l = 0; l < 4; l++)
        if (lane_en[l]) mem[idx][8*l +: 8] <= wr_word[8*l +: 8];
    end
  end

  assign rd_word  = mem[idx];
  assign byte_sel = rd_word[8*addr[1:0] +: 8];
  assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (bus.mem_funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      3'b010:  load_ext = rd_word;
      default: load_ext = '0;
    endcase
  end

  // Forwarded fields hold between instructions; load data and fault flag clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      exec_q    <= '0;
      mdat_q    <= '0;
      pc_q      <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      res_src_q <= 1'b0;
      mis_q     <= 1'b0;
    end else if (complete) begin
      valid_q   <= 1'b1;
      exec_q    <= bus.exec_data_in;
      mdat_q    <= (bus.mem_read_enable && !bus.mem_write_enable && !fault) ? load_ext : '0;
      pc_q      <= bus.next_pc_in;
      rd_we_q   <= bus.rd_write_enable_in && !fault;
      rd_addr_q <= bus.rd_write_addr_in;
      res_src_q <= bus.res_src_in;
      mis_q     <= fault;
    end else begin
      valid_q <= 1'b0;
      mdat_q  <= '0;
      mis_q   <= 1'b0;
    end
  end

  assign bus.valid_out           = valid_q;
  assign bus.exec_data_out       = exec_q;
  assign bus.mem_data_out        = mdat_q;
  assign bus.next_pc_out         = pc_q;
  assign bus.rd_write_enable_out = rd_we_q;
  assign bus.rd_write_addr_out   = rd_addr_q;
  assign bus.res_src_out         = res_src_q;
  assign bus.misaligned_out      = mis_q;
endmodule

// File: tb/tb_memacc_lsu.sv
// Directed bench for memacc_lsu: a single-cycle instance (ia) and a 3-cycle instance (ib).
module tb_memacc_lsu;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  memacc_lsu_if #(.XLEN(32), .REG_AW(5)) ia ();
  memacc_lsu_if #(.XLEN(32), .REG_AW(5)) ib ();

  memacc_lsu #(.XLEN(32), .MEM_DEPTH(16), .MEM_LATENCY(1), .REG_AW(5)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  memacc_lsu #(.XLEN(32), .MEM_DEPTH(16), .MEM_LATENCY(3), .REG_AW(5)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_a(input bit r, input bit w, input logic [2:0] f3,
                      input logic [31:0] ad, input logic [31:0] wd);
    ia.valid_in = 1'b1; ia.mem_read_enable = r; ia.mem_write_enable = w;
    ia.mem_funct3 = f3; ia.exec_data_in = ad; ia.mem_write_data = wd;
    ia.next_pc_in = 32'h1000 + ad; ia.rd_write_enable_in = r & ~w;
    ia.rd_write_addr_in = 5'd7; ia.res_src_in = r;
  endtask

  task automatic op_b(input bit r, input bit w, input logic [2:0] f3,
                      input logic [31:0] ad, input logic [31:0] wd);
    ib.valid_in = 1'b1; ib.mem_read_enable = r; ib.mem_write_enable = w;
    ib.mem_funct3 = f3; ib.exec_data_in = ad; ib.mem_write_data = wd;
    ib.next_pc_in = 32'h2000 + ad; ib.rd_write_enable_in = r & ~w;
    ib.rd_write_addr_in = 5'd9; ib.res_src_in = r;
  endtask

  task automatic idle_a();
    ia.valid_in = 1'b0; ia.mem_read_enable = 1'b0; ia.mem_write_enable = 1'b0;
  endtask

  task automatic idle_b();
    ib.valid_in = 1'b0; ib.mem_read_enable = 1'b0; ib.mem_write_enable = 1'b0;
  endtask

  task automatic wait_b(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ib.valid_out) break;
    end
    chk(tag, 32'(ib.valid_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ia.flush = 1'b0; ib.flush = 1'b0;
    op_a(0, 0, 3'b010, 0, 0); op_b(0, 0, 3'b010, 0, 0);
    idle_a(); idle_b();
    #3;
    chk("rst_vld_a",   32'(ia.valid_out), 0);
    chk("rst_stall_b", 32'(ib.stall), 0);
    chk("rst_mdat_a",  ia.mem_data_out, 0);
    #20;
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: store then load back, single-cycle
    op_a(0, 1, 3'b010, 4, 32'hABCDABCD); tick();
    chk("t1_sw_vld", 32'(ia.valid_out), 1);
    chk("t1_sw_mdat", ia.mem_data_out, 0);
    op_a(1, 0, 3'b010, 4, 0); tick();
    chk("t1_lw", ia.mem_data_out, 32'hABCDABCD);
    chk("t1_lw_vld", 32'(ia.valid_out), 1);
    chk("t1_lw_mis", 32'(ia.misaligned_out), 0);
    chk("t1_lw_rdwe", 32'(ia.rd_write_enable_out), 1);
    chk("t1_lw_rdad", 32'(ia.rd_write_addr_out), 7);
    chk("t1_lw_pc", ia.next_pc_out, 32'h1004);

    // 2: sub-word loads and a byte store
    op_a(1, 0, 3'b000, 5, 0); tick(); chk("t2_lb",  ia.mem_data_out, 32'hFFFFFFAB);
    op_a(1, 0, 3'b100, 5, 0); tick(); chk("t2_lbu", ia.mem_data_out, 32'h000000AB);
    op_a(1, 0, 3'b001, 6, 0); tick(); chk("t2_lh",  ia.mem_data_out, 32'hFFFFABCD);
    op_a(1, 0, 3'b101, 4, 0); tick(); chk("t2_lhu", ia.mem_data_out, 32'h0000ABCD);
    op_a(0, 1, 3'b000, 6, 32'h12); tick();
    op_a(1, 0, 3'b010, 4, 0); tick(); chk("t2_sb_lw", ia.mem_data_out, 32'hAB12ABCD);

    idle_a(); tick();
    chk("idle_vld",  32'(ia.valid_out), 0);
    chk("idle_mdat", ia.mem_data_out, 0);
    chk("idle_hold", ia.exec_data_out, 4);

    // 3: faults leave memory untouched
    op_a(0, 1, 3'b010, 8, 32'h11223344); tick();
    op_a(1, 0, 3'b010, 6, 0); tick();
    chk("t3_lw6_mis",  32'(ia.misaligned_out), 1);
    chk("t3_lw6_rdwe", 32'(ia.rd_write_enable_out), 0);
    chk("t3_lw6_mdat", ia.mem_data_out, 0);
    chk("t3_lw6_vld",  32'(ia.valid_out), 1);
    op_a(0, 1, 3'b001, 9, 32'hFFFF); ia.rd_write_enable_in = 1'b1; tick();
    chk("t3_sh9_mis",  32'(ia.misaligned_out), 1);
    chk("t3_sh9_rdwe", 32'(ia.rd_write_enable_out), 0);
    op_a(1, 0, 3'b011, 0, 0); tick();
    chk("t3_f3_011_mis", 32'(ia.misaligned_out), 1);
    op_a(1, 0, 3'b010, 8, 0); tick();
    chk("t3_lw8", ia.mem_data_out, 32'h11223344);
    chk("t3_lw8_mis", 32'(ia.misaligned_out), 0);
    op_a(1, 1, 3'b010, 8, 32'h55667788); tick();
    chk("t3_rw_mdat", ia.mem_data_out, 0);
    op_a(1, 0, 3'b010, 8, 0); tick();
    chk("t3_rw_store", ia.mem_data_out, 32'h55667788);
    idle_a();

    // 4: three-cycle load with stall, then an ALU op
    op_b(0, 1, 3'b010, 4, 32'h12345678); wait_b("t4_sw_done");
    op_b(1, 0, 3'b010, 4, 0); #1;
    chk("t4_stall0", 32'(ib.stall), 1);
    tick();
    chk("t4_stall1", 32'(ib.stall), 1);
    chk("t4_vld1",   32'(ib.valid_out), 0);
    tick();
    chk("t4_stall2", 32'(ib.stall), 0);
    chk("t4_vld2",   32'(ib.valid_out), 0);
    tick();
    chk("t4_vld3",  32'(ib.valid_out), 1);
    chk("t4_lw",    ib.mem_data_out, 32'h12345678);
    chk("t4_rdad",  32'(ib.rd_write_addr_out), 9);
    ib.valid_in = 1'b1; ib.mem_read_enable = 1'b0; ib.mem_write_enable = 1'b0;
    ib.exec_data_in = 32'h55; #1;
    chk("t4_alu_stall", 32'(ib.stall), 0);
    tick();
    chk("t4_alu_vld",  32'(ib.valid_out), 1);
    chk("t4_alu_mdat", ib.mem_data_out, 0);
    chk("t4_alu_exec", ib.exec_data_out, 32'h55);
    idle_b();

    // 5: flush coinciding with the store's completion edge cancels it
    op_b(0, 1, 3'b010, 8, 32'h00C0FFEE); wait_b("t5_sw_old_done");
    op_b(0, 1, 3'b010, 8, 32'hCDEFCDEF);
    tick(); tick();
    ib.flush = 1'b1;
    tick();
    ib.flush = 1'b0; idle_b(); #1;
    chk("t5_flush_vld",   32'(ib.valid_out), 0);
    chk("t5_flush_stall", 32'(ib.stall), 0);
    op_b(1, 0, 3'b010, 8, 0); wait_b("t5_lw_done");
    chk("t5_lw_old", ib.mem_data_out, 32'h00C0FFEE);

    // 6: asynchronous reset in the middle of WAIT
    op_b(1, 0, 3'b010, 4, 0); tick();
    chk("t6_pre_stall", 32'(ib.stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(ib.stall), 0);
    chk("t6_rst_vld",   32'(ib.valid_out), 0);
    chk("t6_rst_exec",  ib.exec_data_out, 0);
    chk("t6_rst_pc",    ib.next_pc_out, 0);
    chk("t6_rst_exec_a", ia.exec_data_out, 0);
    idle_b();
    @(posedge clk); #1 rst_n = 1'b1;
    op_a(1, 0, 3'b010, 32'd68, 0); tick();
    chk("t6_alias", ia.mem_data_out, 32'hAB12ABCD);
    idle_a(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/memacc_lsu.md
Name: memacc_lsu

Overview:
Parametrised memory-access pipeline stage for the RV32 core, sitting between execute and writeback. It replaces the word-only stage with a load/store unit that supports the following:
- byte, halfword and word accesses with sign/zero extension
- misalignment detection
- configurable memory depth and access latency
- a valid/stall handshake toward execute
It forwards writeback control (next_pc, rd, res_src) alongside the loaded data.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
MEM_DEPTH, 1024, data memory size in 32-bit words; power of two, at least 2.
MEM_LATENCY, 1, cycles from accepting a memory op to its result; range 1 to 15.
REG_AW, 5, register-file address width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills the in-flight instruction
valid_in  in  1  execute presents an instruction
exec_data_in  in  XLEN  ALU result, used as byte address for memory ops
mem_read_enable  in  1  instruction is a load
mem_write_enable  in  1  instruction is a store
mem_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_write_data  in  XLEN  store data (low bytes used for B/H)
next_pc_in  in  XLEN  forwarded
rd_write_enable_in  in  1  forwarded
rd_write_addr_in  in  REG_AW  forwarded
res_src_in  in  1  forwarded
stall  out  1  execute must hold all inputs while high
valid_out  out  1  outputs below carry a completed instruction
exec_data_out  out  XLEN  registered exec_data_in
mem_data_out  out  XLEN  extended load result, 0 for non-loads
next_pc_out  out  XLEN  registered
rd_write_enable_out  out  1  registered, forced 0 on fault
rd_write_addr_out  out  REG_AW  registered
res_src_out  out  1  registered
misaligned_out  out  1  access fault for this instruction

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE, wait counter 0, all outputs 0 (stall 0, valid_out 0). Memory contents are not reset.
- Word index is addr[log2(MEM_DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH bytes.
- Fault conditions:
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - funct3 in {011, 110, 111} with read or write enabled
- On fault: no memory write, mem_data_out=0, misaligned_out=1, rd_write_enable_out=0, valid_out still 1.
- Loads:
  - B/BU select byte addr[1:0]; H/HU select halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Stores:
  - Byte-lane write: B writes lane addr[1:0] from data[7:0]; H writes lanes by addr[1] from data[15:0]; W writes all lanes.
  - The write commits on the completion edge only.
- Read and write both set: treated as a store; mem_data_out=0.
- Non-memory instructions (valid_in, neither enable set): one-cycle pass-through, stall never asserted.
- FSM states IDLE and WAIT:
  - IDLE with valid_in and a memory op and MEM_LATENCY>1: go to WAIT, counter=MEM_LATENCY-1. stall is high combinationally from this cycle until the completion cycle inclusive-minus-one; valid_out=0.
  - WAIT: decrement counter each cycle. At counter==1 the op completes on the next edge: outputs are registered, the store commits, valid_out=1 for one cycle, and the FSM returns to IDLE. stall drops in that completion cycle.
  - MEM_LATENCY=1: memory ops complete in one cycle like pass-through; WAIT is never entered.
- Total latency: valid_in to valid_out is MEM_LATENCY cycles for memory ops and 1 cycle otherwise.
- valid_in low in IDLE: valid_out=0 next cycle. Data outputs hold their previous values except mem_data_out and misaligned_out, which go to 0.
- flush (priority over everything except reset):
  - Next edge: valid_out=0, FSM to IDLE, stall=0.
  - An uncommitted store is cancelled, including one whose completion edge coincides with flush.
- Back-to-back: a load in the cycle after a store to the same word returns the new data.

Test Plan:
1. MEM_LATENCY=1: SW addr 4 data ABCDABCD, then LW addr 4 -> next cycle mem_data_out=ABCDABCD, valid_out=1, misaligned_out=0.
2. After test 1, do the following loads in turn:
   - LB addr 5 -> FFFFFFAB
   - LBU addr 5 -> 000000AB
   - LH addr 6 -> FFFFABCD
   - LHU addr 4 -> 0000ABCD
   Then SB addr 6 data 12, LW addr 4 -> AB12ABCD.
3. LW addr 6, then SH addr 9 data FFFF -> each gives misaligned_out=1, rd_write_enable_out=0, mem_data_out=0. A later LW addr 8 shows memory unchanged.
4. MEM_LATENCY=3: LW addr 4 with valid_in -> stall high exactly 2 cycles, valid_out=1 on the 3rd edge with correct data. An ALU op issued next completes in 1 cycle with mem_data_out=0.
5. MEM_LATENCY=3: SW addr 8 data CDEFCDEF, flush asserted in the cycle before completion -> valid_out stays 0, stall drops, and a subsequent LW addr 8 returns the old value.
6. Assert rst_n low mid-WAIT (asynchronous, between edges) -> stall, valid_out and all outputs 0 immediately. Address 4*MEM_DEPTH+4 aliases to address 4.
